spram_frame_buffer: RTL

- Frame buffer controller that sits directly upstream of the single-port RAM and drives its write enable, address and data.
- Accepts one frame of words on a valid/ready input stream and writes them to consecutive RAM addresses from 0.
- Then reads the frame back through the RAM's asynchronous read port and replays it on a valid/ready output stream.
- One frame is in flight at a time: input and output phases never overlap.

---
 rtl/spram_frame_buffer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/spram_frame_buffer.sv
// spram_frame_buffer
//   Frame buffer controller placed directly upstream of a single-port RAM with
//   an asynchronous read port. One frame is written into RAM from address 0
//   (FILL), the first word is fetched (LOAD), and the frame is replayed on the
//   output stream (DRAIN). Input and output phases never overlap.
//
//   Optional build macro SPRAM_FRAME_CLEAR_EN: after the final output
//   handshake the controller enters CLEAR and writes zero to every RAM
//   address (one per cycle) before returning to FILL.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       input stream handshake
//   in_data, in_last        input word and end-of-frame marker
//   out_valid/out_ready     output stream handshake
//   out_data, out_last      registered output word and end-of-frame marker
//   ram_we, ram_address     RAM write enable and address
//   ram_data, ram_q         RAM write data and asynchronous read data
//   busy                    high in any state other than FILL
//   overflow                sticky: a frame was truncated at DEPTH words
module spram_frame_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic                     ram_we,
  output logic [$clog2(DEPTH)-1:0] ram_address,
  output logic [WIDTH-1:0]         ram_data,
  input  logic [WIDTH-1:0]         ram_q,
  output logic                     busy,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_inc;
  logic            accept;
  logic            close;
  logic            out_hs;

  // Pointers stop at the last RAM word so they never index past DEPTH-1,
  // even when DEPTH is a power of two and the increment would wrap.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1))
      return p;
    else
      return p + AW'(1);
  endfunction

  assign count_inc = count + CW'(1);
  assign out_hs    = out_valid && out_ready;
  assign busy      = (state != FILL);

  always_ff @(posedge clock) begin
    if (reset)
      state <= FILL;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    ram_we      = 1'b0;
    ram_address = '0;
    ram_data    = in_data;
    accept      = 1'b0;
    close       = 1'b0;
    case (state)
      FILL: begin
        in_ready    = 1'b1;
        ram_address = wr_ptr;
        accept      = in_valid;
        ram_we      = accept;
        close       = accept && (in_last || (count_inc == CW'(DEPTH)));
        if (close)
          state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = DRAIN;
      end
      DRAIN: begin
        // Present the next word's address so ram_q is ready at the handshake.
        ram_address = rd_ptr;
        if (out_hs && out_last) begin
`ifdef SPRAM_FRAME_CLEAR_EN
          state_nxt = CLEAR;
`else
          state_nxt = FILL;
`endif
        end
      end
`ifdef SPRAM_FRAME_CLEAR_EN
      CLEAR: begin
        ram_we      = 1'b1;
        ram_data    = '0;
        ram_address = wr_ptr;
        if (wr_ptr == AW'(DEPTH - 1))
          state_nxt = FILL;
      end
`endif
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            count  <= count_inc;
            wr_ptr <= ptr_inc(wr_ptr);
            if (close && !in_last)
              overflow <= 1'b1;
          end
        end
        LOAD: begin
          out_data  <= ram_q;
          out_last  <= (count == CW'(1));
          out_valid <= 1'b1;
          rd_ptr    <= AW'(1);
        end
        DRAIN: begin
          if (out_hs) begin
            if (!out_last) begin
              out_data <= ram_q;
              out_last <= ({1'b0, rd_ptr} == (count - CW'(1)));
              rd_ptr   <= ptr_inc(rd_ptr);
            end else begin
              out_valid <= 1'b0;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              count     <= '0;
            end
          end
        end
`ifdef SPRAM_FRAME_CLEAR_EN
        CLEAR: begin
          if (wr_ptr == AW'(DEPTH - 1))
            wr_ptr <= '0;
          else
            wr_ptr <= wr_ptr + AW'(1);
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
